// File: rtl/dma_done_arb_if.sv
// Bundle of producer write channels, done-queue read port and status readback
// for dma_done_arb. slave is the arbiter side, master is the producer/reader side.
interface dma_done_arb_if #(
  parameter int P_SLOT_TAG_WIDTH = 10,
  parameter int P_DATA_WIDTH     = P_SLOT_TAG_WIDTH + 15,
  parameter int P_NUM_CH         = 4,
  parameter int P_CNT_WIDTH      = 8
);
  logic [P_NUM_CH-1:0]              ch_done_wr_en;
  logic [P_NUM_CH*P_DATA_WIDTH-1:0] ch_done_wr_data;
  logic [P_NUM_CH-1:0]              ch_done_wr_rdy_n;
  logic                             dma_done_rd_en;
  logic [P_DATA_WIDTH-1:0]          dma_done_rd_data;
  logic                             dma_done_empty_n;
  logic                             dma_done_full_n;
  logic [P_NUM_CH*P_CNT_WIDTH-1:0]  ch_done_cnt;
  logic [P_NUM_CH-1:0]              ch_drop_err;

  modport slave (
    input  ch_done_wr_en, ch_done_wr_data, dma_done_rd_en,
    output ch_done_wr_rdy_n, dma_done_rd_data, dma_done_empty_n,
           dma_done_full_n, ch_done_cnt, ch_drop_err
  );

  modport master (
    output ch_done_wr_en, ch_done_wr_data, dma_done_rd_en,
    input  ch_done_wr_rdy_n, dma_done_rd_data, dma_done_empty_n,
           dma_done_full_n, ch_done_cnt, ch_drop_err
  );
endinterface

// File: rtl/dma_done_arb.sv
// Round-robin merge of P_NUM_CH DMA-done channels into one FWFT done queue.
// Define DMA_DONE_ARB_CH0_PRIO_EN to give channel 0 strict priority over the rest.
module dma_done_arb #(
  parameter int P_SLOT_TAG_WIDTH = 10,
  parameter int P_DATA_WIDTH     = P_SLOT_TAG_WIDTH + 15,
  parameter int P_NUM_CH         = 4,
  parameter int P_FIFO_DEPTH     = 8,
  parameter int P_CNT_WIDTH      = 8
) (
  input  logic          pcie_user_clk,
  input  logic          pcie_user_rst,
  dma_done_arb_if.slave done_if
);
  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int PW = $clog2(P_NUM_CH);
  localparam logic [AW:0] DEPTH = (AW+1)'(P_FIFO_DEPTH);
  localparam logic [PW:0] NCH   = (PW+1)'(P_NUM_CH);
  localparam logic [PW-1:0] LAST_CH = PW'(P_NUM_CH - 1);

  logic [P_NUM_CH-1:0]     hold_valid;
  logic [P_DATA_WIDTH-1:0] hold_data [P_NUM_CH];
  logic [P_NUM_CH-1:0]     drop_err;
  logic [P_CNT_WIDTH-1:0]  cnt [P_NUM_CH];
  logic [PW-1:0]           rr_ptr;

  logic [P_DATA_WIDTH-1:0] mem [P_FIFO_DEPTH];
  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic [AW:0]             count;
  logic                    room;
  logic                    pop;

  logic                    grant_vld;
  logic [PW-1:0]           grant_idx;
  logic [PW:0]             scan_sum;
  logic [PW-1:0]           scan_idx;

  assign count = wr_ptr - rd_ptr;
  assign room  = (count < DEPTH);
  assign pop   = done_if.dma_done_rd_en && (count != '0);

  // Room is judged on the pre-pop count, so a pop while full never frees a grant slot that cycle.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (room) begin
`ifdef DMA_DONE_ARB_CH0_PRIO_EN
      if (hold_valid[0]) begin
        grant_vld = 1'b1;
        grant_idx = '0;
      end
`endif
      for (int unsigned i = 0; i < unsigned'(P_NUM_CH); i++) begin
        scan_sum = {1'b0, rr_ptr} + (PW+1)'(i);
        if (scan_sum >= NCH) scan_sum = scan_sum - NCH;
        scan_idx = scan_sum[PW-1:0];
`ifdef DMA_DONE_ARB_CH0_PRIO_EN
        if (!grant_vld && hold_valid[scan_idx] && (scan_idx != '0)) begin
`else
        if (!grant_vld && hold_valid[scan_idx]) begin
`endif
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  always_ff @(posedge pcie_user_clk or posedge pcie_user_rst) begin
    if (pcie_user_rst) begin
      hold_valid <= '0;
      drop_err   <= '0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      for (int unsigned k = 0; k < unsigned'(P_NUM_CH); k++) cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < unsigned'(P_NUM_CH); k++) begin
        if (grant_vld && (grant_idx == PW'(k))) begin
          hold_valid[k] <= 1'b0;
          cnt[k]        <= cnt[k] + 1'b1;
        end
        if (done_if.ch_done_wr_en[k]) begin
          if (hold_valid[k]) drop_err[k]   <= 1'b1;
          else               hold_valid[k] <= 1'b1;
        end
      end
      if (grant_vld) begin
        wr_ptr <= wr_ptr + 1'b1;
`ifdef DMA_DONE_ARB_CH0_PRIO_EN
        if (grant_idx != '0)
`endif
          rr_ptr <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge pcie_user_clk) begin
    for (int unsigned k = 0; k < unsigned'(P_NUM_CH); k++) begin
      if (done_if.ch_done_wr_en[k] && !hold_valid[k])
        hold_data[k] <= done_if.ch_done_wr_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
    end
    if (grant_vld) mem[wr_ptr[AW-1:0]] <= hold_data[grant_idx];
  end

  always_comb begin
    done_if.ch_done_cnt = '0;
    for (int unsigned k = 0; k < unsigned'(P_NUM_CH); k++)
      done_if.ch_done_cnt[k*P_CNT_WIDTH +: P_CNT_WIDTH] = cnt[k];
  end

  assign done_if.ch_done_wr_rdy_n = hold_valid;
  assign done_if.ch_drop_err      = drop_err;
  assign done_if.dma_done_empty_n = (count != '0);
  assign done_if.dma_done_full_n  = room;
  assign done_if.dma_done_rd_data = (count != '0) ? mem[rd_ptr[AW-1:0]] : '0;
endmodule
